// File: rtl/saph_num_unpack_seq_if.sv
// Handshake bundle for saph_num_unpack_seq: word input, field output, config and status.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface saph_num_unpack_seq_if #(
  parameter int word_width   = 32,
  parameter int pack_width   = 8,
  parameter int unpack_width = 8
);
  localparam int cfg_bits = $clog2(pack_width + 1);

  logic [cfg_bits-1:0]     cfg_width;
  logic [word_width-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [unpack_width-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    flush;
  logic                    busy;

  modport master (
    output cfg_width, in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  cfg_width, in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/saph_num_unpack_seq.sv
// Field unpacker: slices packed words LSB-first at a runtime width and widens each
// field by MSB replication (saph_num_exp) for the per-channel colour path.

module saph_num_exp #(
  parameter int pack_width   = 8,
  parameter int unpack_width = 8
) (
  input  logic [pack_width-1:0]            exp_in,
  input  logic [$clog2(pack_width+1)-1:0]  width,
  output logic [unpack_width-1:0]          exp_out
);
  localparam int wb = $clog2(pack_width + 1);
  localparam int pb = (pack_width > 1) ? $clog2(pack_width) : 1;
  localparam logic [wb-1:0] w_max = wb'(pack_width);
  localparam logic [wb-1:0] w_top = wb'(pack_width - 1);
  localparam logic [wb-1:0] w_one = wb'(32'd1);

  logic [wb-1:0] w_eff_s;
  logic [wb-1:0] cnt_s;

  // Walk output bits MSB-down, re-reading the aligned field every w bits.
  always_comb begin
    exp_out = {unpack_width{1'b0}};
    cnt_s   = {wb{1'b0}};
    if (width == {wb{1'b0}} || width > w_max) begin
      w_eff_s = w_max;
    end else begin
      w_eff_s = width;
    end
    for (int x = 0; x < unpack_width; x++) begin
      exp_out[unpack_width-1-x] = exp_in[pb'(w_top - cnt_s)];
      if (cnt_s + w_one >= w_eff_s) begin
        cnt_s = {wb{1'b0}};
      end else begin
        cnt_s = cnt_s + w_one;
      end
    end
  end
endmodule

module saph_num_unpack_seq #(
  parameter int word_width   = 32,
  parameter int pack_width   = 8,
  parameter int unpack_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  saph_num_unpack_seq_if.slave bus
);
  localparam int wb = $clog2(pack_width + 1);
  localparam int kb = $clog2(word_width + 1);
  localparam logic [wb-1:0] w_max = wb'(pack_width);
  localparam logic [wb-1:0] w_one = wb'(32'd1);
  localparam logic [kb-1:0] k_one = kb'(32'd1);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                  state_r, state_n;
  logic [word_width-1:0]   buf_r, buf_n;
  logic [wb-1:0]           w_r, w_n, w_legal_s;
  logic [kb-1:0]           k_r, k_n, n_r, n_n;
  logic                    last_s, in_ready_s;
  logic [kb+wb-1:0]        off_s;
  logic [word_width-1:0]   shifted_s;
  logic [pack_width-1:0]   mask_s, field_s, exp_in_s;
  logic [unpack_width-1:0] exp_out_s;

  // Constant table of floor(word_width / w); out-of-range widths map to pack_width.
  function automatic logic [kb-1:0] field_count(input logic [wb-1:0] w);
    field_count = kb'(word_width / pack_width);
    for (int i = 1; i <= pack_width; i++) begin
      field_count = (w == wb'(i)) ? kb'(word_width / i) : field_count;
    end
  endfunction

  // Legalise the configured width as seen at word accept.
  always_comb begin
    if (bus.cfg_width >= w_one && bus.cfg_width <= w_max) begin
      w_legal_s = bus.cfg_width;
    end else begin
      w_legal_s = w_max;
    end
  end

  assign off_s     = {{wb{1'b0}}, k_r} * {{kb{1'b0}}, w_r};
  assign shifted_s = buf_r >> off_s;
  assign mask_s    = ~({pack_width{1'b1}} << w_r);
  assign field_s   = shifted_s[pack_width-1:0] & mask_s;
  assign exp_in_s  = field_s << (w_max - w_r);
  assign last_s    = (k_r == n_r - k_one);

  saph_num_exp #(
    .pack_width   (pack_width),
    .unpack_width (unpack_width)
  ) u_exp (
    .exp_in  (exp_in_s),
    .width   (w_r),
    .exp_out (exp_out_s)
  );

  assign bus.out_data  = exp_out_s;
  assign bus.out_valid = (state_r == EMIT);
  assign bus.out_last  = (state_r == EMIT) & last_s;
  assign bus.busy      = (state_r == EMIT);
  assign bus.in_ready  = in_ready_s;

  // Next-state: accept in IDLE, step fields in EMIT; the last handshake may reload directly.
  always_comb begin
    state_n    = state_r;
    buf_n      = buf_r;
    w_n        = w_r;
    n_n        = n_r;
    k_n        = k_r;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          buf_n   = bus.in_data;
          w_n     = w_legal_s;
          n_n     = field_count(w_legal_s);
          k_n     = {kb{1'b0}};
          state_n = EMIT;
        end else begin
          state_n = IDLE;
        end
      end
      EMIT: begin
        in_ready_s = bus.out_ready & last_s & ~bus.flush;
        if (bus.flush) begin
          state_n = IDLE;
        end else if (bus.out_ready && !last_s) begin
          k_n = k_r + k_one;
        end else if (bus.out_ready && bus.in_valid) begin
          buf_n   = bus.in_data;
          w_n     = w_legal_s;
          n_n     = field_count(w_legal_s);
          k_n     = {kb{1'b0}};
          state_n = EMIT;
        end else if (bus.out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = EMIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and word-holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      buf_r   <= {word_width{1'b0}};
      w_r     <= {wb{1'b0}};
      n_r     <= {kb{1'b0}};
      k_r     <= {kb{1'b0}};
    end else begin
      state_r <= state_n;
      buf_r   <= buf_n;
      w_r     <= w_n;
      n_r     <= n_n;
      k_r     <= k_n;
    end
  end
endmodule

// File: tb/tb_saph_num_unpack_seq.sv
// Self-checking bench for saph_num_unpack_seq: directed plan steps plus random traffic
// compared cycle by cycle with a queue-based reference of the expected field stream.
module tb_saph_num_unpack_seq;
  localparam int WW = 32;
  localparam int PW = 8;
  localparam int UW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  saph_num_unpack_seq_if #(.word_width(WW), .pack_width(PW), .unpack_width(UW)) bus();

  saph_num_unpack_seq #(.word_width(WW), .pack_width(PW), .unpack_width(UW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] pend_w[$];
  logic [3:0]  pend_c[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] m_expand(input int field, input int w);
    int v = 0;
    for (int x = 0; x < UW; x++) v = v * 2 + ((field >> (w - 1 - (x % w))) & 1);
    return v[7:0];
  endfunction

  task automatic m_load(input logic [31:0] word, input logic [3:0] c);
    int w;
    int n;
    w = (c >= 1 && c <= PW) ? int'(c) : PW;
    n = WW / w;
    for (int k = 0; k < n; k++) exp_q.push_back(m_expand(int'((word >> (k * w)) & ((32'd1 << w) - 32'd1)), w));
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic [3:0] c,
                       input logic ordy, input logic fl, output bit acc);
    bit busy_m;
    bit irdy_m;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.cfg_width = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    busy_m = (exp_q.size() > 0);
    irdy_m = !busy_m || (ordy && exp_q.size() == 1 && !fl);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, busy_m});
    chk("busy", {31'd0, bus.busy}, {31'd0, busy_m});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, irdy_m});
    if (busy_m) begin
      chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0]});
      chk("out_last", {31'd0, bus.out_last}, {31'd0, (exp_q.size() == 1)});
      if (prev_stall) chk("stall_hold", {24'd0, bus.out_data}, {24'd0, prev_data});
    end
    prev_stall = busy_m && !ordy && !fl;
    prev_data  = bus.out_data;
    acc = iv && irdy_m;
    if (busy_m && ordy) got_q.push_back(bus.out_data);
    if (busy_m && fl) exp_q.delete();
    else if (busy_m && ordy) void'(exp_q.pop_front());
    if (acc) m_load(d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic run_pending(input int mode);
    int cyc = 0;
    bit acc;
    bit ordy;
    while ((pend_w.size() > 0 || exp_q.size() > 0) && cyc < 300) begin
      ordy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (pend_w.size() > 0) cycle(1'b1, pend_w[0], pend_c[0], ordy, 1'b0, acc);
      else cycle(1'b0, 32'd0, 4'd8, ordy, 1'b0, acc);
      if (acc) begin
        void'(pend_w.pop_front());
        void'(pend_c.pop_front());
      end
      cyc++;
    end
    chk("timeout", {31'd0, (cyc < 300)}, 32'd1);
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.cfg_width = 4'd8;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // plain slicing
    got_q.delete(); pend_w.push_back(32'hDEADBEEF); pend_c.push_back(4'd8);
    run_pending(0);
    cycle(1'b0, 32'd0, 4'd8, 1'b1, 1'b0, acc);
    chk("slice_n", got_q.size(), 32'd4);
    chk("slice0", {24'd0, got_q[0]}, 32'hEF); chk("slice1", {24'd0, got_q[1]}, 32'hBE);
    chk("slice2", {24'd0, got_q[2]}, 32'hAD); chk("slice3", {24'd0, got_q[3]}, 32'hDE);

    // expansion, w=5
    got_q.delete(); pend_w.push_back(32'h00000016); pend_c.push_back(4'd5);
    run_pending(0);
    chk("exp_n", got_q.size(), 32'd6);
    chk("exp0", {24'd0, got_q[0]}, 32'hB5);
    for (int i = 1; i < 6; i++) chk("exp_zero", {24'd0, got_q[i]}, 32'h00);

    // back-pressure, w=4
    got_q.delete(); pend_w.push_back(32'h0000A5C3); pend_c.push_back(4'd4);
    run_pending(1);
    chk("bp_n", got_q.size(), 32'd8);
    chk("bp0", {24'd0, got_q[0]}, 32'h33); chk("bp1", {24'd0, got_q[1]}, 32'hCC);
    chk("bp2", {24'd0, got_q[2]}, 32'h55); chk("bp3", {24'd0, got_q[3]}, 32'hAA);
    for (int i = 4; i < 8; i++) chk("bp_zero", {24'd0, got_q[i]}, 32'h00);

    // back-to-back words, no bubble (model requires out_valid every cycle)
    got_q.delete();
    pend_w.push_back(32'h11223344); pend_c.push_back(4'd8);
    pend_w.push_back(32'h55667788); pend_c.push_back(4'd8);
    run_pending(0);
    chk("b2b_n", got_q.size(), 32'd8);
    chk("b2b3", {24'd0, got_q[3]}, 32'h11); chk("b2b4", {24'd0, got_q[4]}, 32'h88);

    // illegal width and w=1
    got_q.delete(); pend_w.push_back(32'hCAFEF00D); pend_c.push_back(4'd0);
    run_pending(0);
    chk("w0_n", got_q.size(), 32'd4);
    chk("w0_first", {24'd0, got_q[0]}, 32'h0D);
    got_q.delete(); pend_w.push_back(32'h00000005); pend_c.push_back(4'd1);
    run_pending(0);
    chk("w1_n", got_q.size(), 32'd32);
    chk("w1_0", {24'd0, got_q[0]}, 32'hFF); chk("w1_1", {24'd0, got_q[1]}, 32'h00);
    chk("w1_2", {24'd0, got_q[2]}, 32'hFF); chk("w1_31", {24'd0, got_q[31]}, 32'h00);

    // flush at k=1
    got_q.delete();
    cycle(1'b1, 32'hA1B2C3D4, 4'd8, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'd0, 4'd8, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'd0, 4'd8, 1'b1, 1'b1, acc);
    cycle(1'b0, 32'd0, 4'd8, 1'b1, 1'b0, acc);
    chk("flush_n", got_q.size(), 32'd2);
    chk("flush_k1", {24'd0, got_q[1]}, 32'hC3);

    // asynchronous reset mid-word
    cycle(1'b1, 32'h12345678, 4'd8, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'd0, 4'd8, 1'b0, 1'b0, acc);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_out_data", {24'd0, bus.out_data}, 32'd0);
    exp_q.delete(); prev_stall = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // random traffic, including cfg changes mid-word and flushes
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 1) == 1), $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), acc);
    end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, 32'd0, 4'd8, 1'b1, 1'b0, acc);
    chk("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
